tone_note_decoder: RTL and testbench



---
 rtl/tone_note_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_tone_note_decoder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_note_decoder.sv
// -----------------------------------------------------------------------------
// tone_note_decoder
//
// Receive-side counterpart of the tone generator's BCD divisor/clear path.
// The period of an incoming tone (one rising edge per generator clear) is
// measured with a 3-digit BCD counter. The measured divisor is matched
// against the eight-note divisor table. The result is reported as a note
// code 1..8, or 0 for pause/unknown, after CONFIRM consecutive identical
// decodes.
//
// Parameters:
//   CONFIRM   consecutive identical decodes needed before `note` changes
//             (legal range 1..7)
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   tone_in   tone line, asynchronous to clk, one rising edge per period
//   note      decoded note code (0 = pause/unknown, 1..8 = notes)
//   note_chg  one-cycle pulse in the cycle `note` takes a new value
//   locked    high while a note 1..8 is held and periods keep arriving
//   per2      BCD hundreds digit of the last captured period
//   per1      BCD tens digit of the last captured period
//   per0      BCD units digit of the last captured period
// -----------------------------------------------------------------------------
module tone_note_decoder #(
    parameter int unsigned CONFIRM = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    output logic [3:0] note,
    output logic       note_chg,
    output logic       locked,
    output logic [3:0] per2,
    output logic [3:0] per1,
    output logic [3:0] per0
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [2:0]  CONFIRM_C = 3'(CONFIRM);
    localparam logic [11:0] COUNT_MAX = 12'h999;

    state_t      state;
    logic        sync1;
    logic        sync2;
    logic        dly;
    logic        rise;
    logic [11:0] count;      // BCD c2:c1:c0
    logic [3:0]  cand;       // decode currently being confirmed
    logic [2:0]  conf_cnt;   // consecutive matches of cand

    logic [3:0]  dec;
    logic [3:0]  cand_next;
    logic [2:0]  cnt_next;
    logic        promote;

    // -------------------------------------------------------------------------
    // BCD increment, saturating at 999. Each digit wraps 9 -> 0 and carries.
    // -------------------------------------------------------------------------
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != COUNT_MAX) begin
            if (r[3:0] == 4'd9) begin
                r[3:0] = 4'd0;
                if (r[7:4] == 4'd9) begin
                    r[7:4]  = 4'd0;
                    r[11:8] = r[11:8] + 4'd1;
                end else begin
                    r[7:4] = r[7:4] + 4'd1;
                end
            end else begin
                r[3:0] = r[3:0] + 4'd1;
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Divisor table: exact BCD match against the generator's divisors.
    // Anything else is pause/unknown.
    // -------------------------------------------------------------------------
    function automatic logic [3:0] decode(input logic [11:0] v);
        logic [3:0] n;
        case (v)
            12'h956: n = 4'd1;
            12'h851: n = 4'd2;
            12'h758: n = 4'd3;
            12'h716: n = 4'd4;
            12'h638: n = 4'd5;
            12'h568: n = 4'd6;
            12'h506: n = 4'd7;
            12'h478: n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // Rising edge of the synchronised tone. The synchroniser and delay flop
    // add a fixed latency, so edge-to-edge spacing is preserved exactly.
    assign rise = sync2 & ~dly;

    // -------------------------------------------------------------------------
    // Confirmation bookkeeping for the decode of the value being captured.
    // These next values are only used when a capture happens.
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        dec       = decode(count);
        cand_next = cand;
        cnt_next  = conf_cnt;
        promote   = 1'b0;

        if (dec == cand) begin
            if (conf_cnt < CONFIRM_C) begin
                cnt_next = conf_cnt + 3'd1;
            end
        end else begin
            cand_next = dec;
            cnt_next  = 3'd1;
        end

        promote = (cnt_next == CONFIRM_C) && (cand_next != note);
    end

    // -------------------------------------------------------------------------
    // Synchroniser, measurement FSM, confirmation and registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // read the pre-edge values, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            dly      <= 1'b0;
            state    <= IDLE;
            count    <= 12'h000;
            cand     <= 4'd0;
            conf_cnt <= 3'd0;
            note     <= 4'd0;
            note_chg <= 1'b0;
            locked   <= 1'b0;
            per2     <= 4'd0;
            per1     <= 4'd0;
            per0     <= 4'd0;
        end else begin
            sync1    <= tone_in;
            sync2    <= sync1;
            dly      <= sync2;
            note_chg <= 1'b0;

            case (state)
                IDLE: begin
                    // The first edge only arms the measurement.
                    count  <= 12'h000;
                    locked <= 1'b0;
                    if (rise) begin
                        state <= MEASURE;
                    end
                end

                MEASURE: begin
                    if (rise) begin
                        // A capture takes priority over the timeout when
                        // both happen in the same cycle.
                        {per2, per1, per0} <= count;
                        count              <= 12'h000;
                        cand               <= cand_next;
                        conf_cnt           <= cnt_next;
                        if (promote) begin
                            note     <= cand_next;
                            note_chg <= 1'b1;
                            locked   <= (cand_next != 4'd0);
                        end else begin
                            locked   <= (note != 4'd0);
                        end
                    end else if (count == COUNT_MAX) begin
                        // Tone stopped: drop the note and return to IDLE.
                        // The last captured period stays visible.
                        state    <= IDLE;
                        note     <= 4'd0;
                        note_chg <= (note != 4'd0);
                        cand     <= 4'd0;
                        conf_cnt <= 3'd0;
                        locked   <= 1'b0;
                    end else begin
                        count  <= bcd_inc(count);
                        locked <= (note != 4'd0);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_note_decoder.sv
// -----------------------------------------------------------------------------
// tb_tone_note_decoder
//
// Scoreboard bench for tone_note_decoder. The driver produces tone edges with
// known spacing. For each edge it runs a period-level reference model built
// from the edge times and the divisor table. Every expected note change is
// queued with its cycle, note, period and lock state. A separate monitor pops
// and compares each entry whenever the DUT pulses note_chg.
// -----------------------------------------------------------------------------
module tb_tone_note_decoder;

    localparam int CONFIRM = 2;
    localparam int LAT     = 3;     // drive -> action edge latency
    localparam int TMO     = 1000;  // edges further apart than this time out

    logic       clk;
    logic       rst_n;
    logic       tone_in;
    logic [3:0] note;
    logic       note_chg;
    logic       locked;
    logic [3:0] per2;
    logic [3:0] per1;
    logic [3:0] per0;

    tone_note_decoder #(.CONFIRM(CONFIRM)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tone_in  (tone_in),
        .note     (note),
        .note_chg (note_chg),
        .locked   (locked),
        .per2     (per2),
        .per1     (per1),
        .per0     (per0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: works on edge times and periods, not on cycles.
    // ------------------------------------------------------------------------
    typedef struct {
        int cyc;
        int note;
        int per;
        int lck;
    } exp_t;

    exp_t exp_q[$];

    int divs [8] = '{956, 851, 758, 716, 638, 568, 506, 478};

    bit m_armed = 1'b0;
    int m_last  = 0;
    int m_note  = 0;
    int m_cand  = 0;
    int m_cnt   = 0;
    int m_per   = 0;

    function automatic int table_note(input int p);
        for (int i = 0; i < 8; i++) begin
            if (divs[i] == p) return i + 1;
        end
        return 0;
    endfunction

    function automatic int to_bcd(input int p);
        return ((p / 100) << 8) | (((p / 10) % 10) << 4) | (p % 10);
    endfunction

    task automatic model_timeout();
        exp_t e;
        if (m_note != 0) begin
            e.cyc  = m_last + TMO;
            e.note = 0;
            e.per  = m_per;
            e.lck  = 0;
            exp_q.push_back(e);
        end
        m_note  = 0;
        m_cand  = 0;
        m_cnt   = 0;
        m_armed = 1'b0;
    endtask

    // a = cycle at which the DUT acts on this edge
    task automatic model_edge(input int a);
        int   p;
        int   d;
        exp_t e;
        if (m_armed && (a - m_last) > TMO) model_timeout();
        if (!m_armed) begin
            m_armed = 1'b1;
            m_last  = a;
            return;
        end
        p      = a - m_last - 1;
        m_per  = to_bcd(p);
        d      = table_note(p);
        if (d == m_cand) begin
            if (m_cnt < CONFIRM) m_cnt++;
        end else begin
            m_cand = d;
            m_cnt  = 1;
        end
        if (m_cnt == CONFIRM && m_cand != m_note) begin
            m_note = m_cand;
            e.cyc  = a;
            e.note = m_note;
            e.per  = m_per;
            e.lck  = (m_note != 0) ? 1 : 0;
            exp_q.push_back(e);
        end
        m_last = a;
    endtask

    // Tone stops: the measurement eventually times out.
    task automatic model_finalize();
        if (m_armed) model_timeout();
    endtask

    task automatic model_reset();
        m_armed = 1'b0;
        m_note  = 0;
        m_cand  = 0;
        m_cnt   = 0;
        m_per   = 0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor: compares every note_chg pulse against the queue.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && note_chg) begin
            if (exp_q.size() == 0) begin
                check("note_chg_unexpected", {31'd0, note_chg}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("chg_cycle", cyc, e.cyc);
                check("chg_note", {28'd0, note}, e.note);
                check("chg_per", {20'd0, per2, per1, per0}, e.per);
                check("chg_locked", {31'd0, locked}, e.lck);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One rising edge, then the line is quiet until p cycles after the edge.
    task automatic drive_edge(input int p);
        int h;
        h = $urandom_range(2, 12);
        @(negedge clk);
        tone_in = 1'b1;
        model_edge(cyc + LAT);
        repeat (h) @(negedge clk);
        tone_in = 1'b0;
        repeat (p - h - 1) @(negedge clk);
    endtask

    function automatic logic [31:0] per_now();
        return {20'd0, per2, per1, per0};
    endfunction

    initial begin
        int p;
        int reps;
        int r;

        rst_n   = 1'b0;
        tone_in = 1'b0;
        idle(4);
        check("rst_note", {28'd0, note}, 32'd0);
        check("rst_note_chg", {31'd0, note_chg}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_per", per_now(), 32'h000);
        rst_n = 1'b1;

        // Quiet line: nothing decodes, nothing pulses.
        idle(2000);
        check("idle_note", {28'd0, note}, 32'd0);
        check("idle_locked", {31'd0, locked}, 32'd0);

        // Note 1: first edge arms, the third edge confirms.
        repeat (3) drive_edge(957);
        check("n1_note", {28'd0, note}, 32'd1);
        check("n1_per", per_now(), 32'h956);
        check("n1_locked", {31'd0, locked}, 32'd1);

        // Switch to note 8.
        repeat (3) drive_edge(479);
        check("n8_note", {28'd0, note}, 32'd8);
        check("n8_per", per_now(), 32'h478);

        // Back to note 1, then alternating periods that never confirm.
        repeat (3) drive_edge(957);
        check("n1b_note", {28'd0, note}, 32'd1);
        repeat (2) begin
            drive_edge(852);
            drive_edge(759);
        end
        check("alt_note", {28'd0, note}, 32'd1);

        // Unknown period confirms to pause.
        repeat (3) drive_edge(600);
        check("unk_note", {28'd0, note}, 32'd0);
        check("unk_per", per_now(), 32'h599);
        check("unk_locked", {31'd0, locked}, 32'd0);

        // Lock on note 6, then stop the tone.
        repeat (3) drive_edge(569);
        check("n6_note", {28'd0, note}, 32'd6);
        check("n6_locked", {31'd0, locked}, 32'd1);
        model_finalize();
        idle(1100);
        check("tmo_note", {28'd0, note}, 32'd0);
        check("tmo_locked", {31'd0, locked}, 32'd0);
        check("tmo_per", per_now(), 32'h568);

        // A single edge after the timeout only re-arms.
        drive_edge(600);
        check("rearm_per", per_now(), 32'h568);
        check("rearm_note", {28'd0, note}, 32'd0);
        model_finalize();
        idle(1100);

        // Lock on note 3, then reset asynchronously mid-period.
        repeat (3) drive_edge(759);
        @(negedge clk);
        tone_in = 1'b1;
        model_edge(cyc + LAT);
        repeat (5) @(negedge clk);
        tone_in = 1'b0;
        repeat (295) @(negedge clk);
        check("pre_rst_note", {28'd0, note}, 32'd3);
        check("pre_rst_queue", exp_q.size(), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_note", {28'd0, note}, 32'd0);
        check("arst_locked", {31'd0, locked}, 32'd0);
        check("arst_per", per_now(), 32'h000);
        model_reset();
        idle(3);
        rst_n = 1'b1;

        repeat (3) drive_edge(507);
        check("n7_note", {28'd0, note}, 32'd7);
        check("n7_per", per_now(), 32'h506);
        check("n7_locked", {31'd0, locked}, 32'd1);

        // Random period bursts, including the 1000/1001 timeout boundary.
        for (int b = 0; b < 25; b++) begin
            r = $urandom_range(0, 9);
            if (r < 6) begin
                p    = divs[$urandom_range(0, 7)] + 1;
                reps = $urandom_range(1, 4);
            end else if (r < 8) begin
                p    = $urandom_range(480, 1000);
                reps = $urandom_range(1, 2);
            end else begin
                p    = ($urandom_range(0, 1) == 0) ? 1000 : 1001;
                reps = 1;
            end
            repeat (reps) drive_edge(p);
        end
        check("rnd_note", {28'd0, note}, m_note);
        check("rnd_per", per_now(), m_per);
        model_finalize();
        idle(1100);
        check("end_note", {28'd0, note}, 32'd0);
        check("end_queue", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
